// File: rtl/rotate_tetromino_pkg.sv
// Shared types and constants for the falling-piece control path.
package rotate_tetromino_pkg;

  localparam int IDX_W   = 3;
  localparam int ROT_W   = 2;
  localparam int COORD_X_W = 5;
  localparam int COORD_Y_W = 6;

  localparam logic [IDX_W-1:0] TETROMINO_I_IDX       = 3'd0;
  localparam logic [IDX_W-1:0] TETROMINO_O_IDX       = 3'd1;
  localparam logic [IDX_W-1:0] TETROMINO_T_IDX       = 3'd2;
  localparam logic [IDX_W-1:0] TETROMINO_S_IDX       = 3'd3;
  localparam logic [IDX_W-1:0] TETROMINO_Z_IDX       = 3'd4;
  localparam logic [IDX_W-1:0] TETROMINO_J_IDX       = 3'd5;
  localparam logic [IDX_W-1:0] TETROMINO_L_IDX       = 3'd6;
  localparam logic [IDX_W-1:0] TETROMINO_INVALID_IDX = 3'd7;

  typedef struct packed {
    logic [IDX_W-1:0] data;
  } tetromino_idx_t;

  typedef struct packed {
    logic signed [COORD_X_W-1:0] x;
    logic signed [COORD_Y_W-1:0] y;
  } coordinate_t;

  // data[0] is the top row; within a row bit 3 is the leftmost column.
  typedef struct packed {
    logic [0:3][3:0] data;
  } tetromino_mask_t;

  typedef struct packed {
    tetromino_idx_t  idx;
    logic [ROT_W-1:0] rotation;
    coordinate_t     coordinate;
    tetromino_mask_t tetromino;
  } tetromino_ctrl;

  function automatic logic [ROT_W-1:0] next_rotation(input logic [ROT_W-1:0] rot,
                                                     input logic            cw);
    next_rotation = cw ? rot + 2'd1 : rot + 2'd3;
  endfunction

endpackage

// File: rtl/rotate_tetromino_shape_rom.sv
// Combinational SRS shape table: (piece, rotation) -> 4x4 occupancy mask.
module tetromino_shape_rom
  import rotate_tetromino_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [ROT_W-1:0] rotation,
  output tetromino_mask_t  mask
);

  logic [15:0] bits;

  // Each nibble is one row, top row in the most significant nibble.
  always_comb begin
    bits = 16'h0000;
    case ({idx, rotation})
      {TETROMINO_I_IDX, 2'd0}: bits = 16'h0F00;
      {TETROMINO_I_IDX, 2'd1}: bits = 16'h2222;
      {TETROMINO_I_IDX, 2'd2}: bits = 16'h00F0;
      {TETROMINO_I_IDX, 2'd3}: bits = 16'h4444;
      {TETROMINO_O_IDX, 2'd0},
      {TETROMINO_O_IDX, 2'd1},
      {TETROMINO_O_IDX, 2'd2},
      {TETROMINO_O_IDX, 2'd3}: bits = 16'h6600;
      {TETROMINO_T_IDX, 2'd0}: bits = 16'h4E00;
      {TETROMINO_T_IDX, 2'd1}: bits = 16'h4640;
      {TETROMINO_T_IDX, 2'd2}: bits = 16'h0E40;
      {TETROMINO_T_IDX, 2'd3}: bits = 16'h4C40;
      {TETROMINO_S_IDX, 2'd0}: bits = 16'h6C00;
      {TETROMINO_S_IDX, 2'd1}: bits = 16'h4620;
      {TETROMINO_S_IDX, 2'd2}: bits = 16'h06C0;
      {TETROMINO_S_IDX, 2'd3}: bits = 16'h8C40;
      {TETROMINO_Z_IDX, 2'd0}: bits = 16'hC600;
      {TETROMINO_Z_IDX, 2'd1}: bits = 16'h2640;
      {TETROMINO_Z_IDX, 2'd2}: bits = 16'h0C60;
      {TETROMINO_Z_IDX, 2'd3}: bits = 16'h4C80;
      {TETROMINO_J_IDX, 2'd0}: bits = 16'h8E00;
      {TETROMINO_J_IDX, 2'd1}: bits = 16'h6440;
      {TETROMINO_J_IDX, 2'd2}: bits = 16'h0E20;
      {TETROMINO_J_IDX, 2'd3}: bits = 16'h44C0;
      {TETROMINO_L_IDX, 2'd0}: bits = 16'h2E00;
      {TETROMINO_L_IDX, 2'd1}: bits = 16'h4460;
      {TETROMINO_L_IDX, 2'd2}: bits = 16'h0E80;
      {TETROMINO_L_IDX, 2'd3}: bits = 16'hC440;
      default:                 bits = 16'h0000;
    endcase
  end

  assign mask = tetromino_mask_t'(bits);

endmodule

// File: rtl/rotate_tetromino.sv
// Single-cycle registered rotation of the active piece; no collision checking.
module rotate_tetromino
  import rotate_tetromino_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clockwise,
  input  tetromino_ctrl t_in,
  output tetromino_ctrl t_out,
  output logic          success,
  output logic          done
);

  logic [ROT_W-1:0] rot_p0;
  tetromino_mask_t  mask_p0;
  tetromino_ctrl    t_p0;
  logic             valid_p0;

  tetromino_ctrl    t_p1;
  logic             done_p1;
  logic             success_p1;

  assign rot_p0   = next_rotation(t_in.rotation, clockwise);
  assign valid_p0 = (t_in.idx.data != TETROMINO_INVALID_IDX);

  tetromino_shape_rom u_rom (
    .idx      (t_in.idx.data),
    .rotation (rot_p0),
    .mask     (mask_p0)
  );

  always_comb begin
    t_p0 = t_in;
    if (valid_p0) begin
      t_p0.rotation  = rot_p0;
      t_p0.tetromino = mask_p0;
    end
  end

  // p0 -> p1: register the rotated piece; it holds while no request is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_p1       <= '0;
      done_p1    <= 1'b0;
      success_p1 <= 1'b0;
    end else begin
      done_p1    <= enable;
      success_p1 <= enable && valid_p0;
      if (enable) t_p1 <= t_p0;
    end
  end

  assign t_out   = t_p1;
  assign done    = done_p1;
  assign success = success_p1;

endmodule

// File: tb/tb_rotate_tetromino.sv
// Directed bench for rotate_tetromino with hand-computed SRS expectations.
module tb_rotate_tetromino;
  import rotate_tetromino_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clockwise;
  tetromino_ctrl t_in;
  tetromino_ctrl t_out;
  logic          success;
  logic          done;

  int pass_cnt = 0;
  int total    = 0;

  rotate_tetromino dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clockwise (clockwise),
    .t_in      (t_in),
    .t_out     (t_out),
    .success   (success),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic tetromino_ctrl mk(input logic [2:0] idx, input logic [1:0] rot,
                                       input logic signed [4:0] x,
                                       input logic signed [5:0] y,
                                       input logic [15:0] mask);
    tetromino_ctrl t;
    t.idx.data       = idx;
    t.rotation       = rot;
    t.coordinate.x   = x;
    t.coordinate.y   = y;
    t.tetromino      = tetromino_mask_t'(mask);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rotate_chk(input string tag, input tetromino_ctrl tin, input logic cw,
                            input tetromino_ctrl exp);
    t_in = tin; clockwise = cw; enable = 1'b1;
    step();
    check({tag, " t_out"}, t_out, exp);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " success"}, 32'(success), 32'd1);
  endtask

  logic [15:0]   i_masks [4];
  tetromino_ctrl held;

  initial begin
    i_masks[0] = 16'h2222; i_masks[1] = 16'h00F0;
    i_masks[2] = 16'h4444; i_masks[3] = 16'h0F00;

    rst_n = 1'b0; enable = 1'b0; clockwise = 1'b1; t_in = '0;
    step();
    check("reset t_out", t_out, 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset success", 32'(success), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    rotate_chk("T r0 cw", mk(3'd2, 2'd0, 5'sd3, 6'sd0, 16'hFFFF), 1'b1,
               mk(3'd2, 2'd1, 5'sd3, 6'sd0, 16'h4640));
    rotate_chk("T r3 cw", mk(3'd2, 2'd3, 5'sd3, 6'sd0, 16'h4C40), 1'b1,
               mk(3'd2, 2'd0, 5'sd3, 6'sd0, 16'h4E00));
    rotate_chk("T r0 ccw", mk(3'd2, 2'd0, 5'sd4, 6'sd7, 16'h4E00), 1'b0,
               mk(3'd2, 2'd3, 5'sd4, 6'sd7, 16'h4C40));
    rotate_chk("T r1 ccw", mk(3'd2, 2'd1, 5'sd4, 6'sd7, 16'h4640), 1'b0,
               mk(3'd2, 2'd0, 5'sd4, 6'sd7, 16'h4E00));

    // Idle cycle: input changes but output must hold.
    held = mk(3'd2, 2'd0, 5'sd4, 6'sd7, 16'h4E00);
    enable = 1'b0;
    t_in = mk(3'd5, 2'd2, -5'sd1, 6'sd9, 16'h1234);
    step();
    check("idle done", 32'(done), 32'd0);
    check("idle success", 32'(success), 32'd0);
    check("idle hold", t_out, held);

    // I piece spun four times by feeding t_out back.
    t_in = mk(3'd0, 2'd0, -5'sd2, 6'sd5, 16'h0F00);
    clockwise = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("I cw %0d", k), t_out,
            mk(3'd0, 2'(k + 1), -5'sd2, 6'sd5, i_masks[k]));
      check($sformatf("I cw %0d done", k), 32'(done), 32'd1);
      t_in = t_out;
    end
    check("I final row1", 32'(t_out.tetromino.data[1]), 32'hF);

    t_in = mk(3'd1, 2'd0, 5'sd4, 6'sd0, 16'h6600);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("O cw %0d", k), t_out,
            mk(3'd1, 2'(k + 1), 5'sd4, 6'sd0, 16'h6600));
      t_in = t_out;
    end

    rotate_chk("Z r0 ccw", mk(3'd4, 2'd0, 5'sd0, -6'sd3, 16'hC600), 1'b0,
               mk(3'd4, 2'd3, 5'sd0, -6'sd3, 16'h4C80));
    rotate_chk("L r1 cw", mk(3'd6, 2'd1, 5'sd7, 6'sd20, 16'h0000), 1'b1,
               mk(3'd6, 2'd2, 5'sd7, 6'sd20, 16'h0E80));
    rotate_chk("S r2 cw", mk(3'd3, 2'd2, -5'sd16, 6'sd1, 16'h06C0), 1'b1,
               mk(3'd3, 2'd3, -5'sd16, 6'sd1, 16'h8C40));
    rotate_chk("J r0 ccw", mk(3'd5, 2'd0, 5'sd2, 6'sd2, 16'h8E00), 1'b0,
               mk(3'd5, 2'd3, 5'sd2, 6'sd2, 16'h44C0));

    t_in = mk(3'd7, 2'd2, -5'sd1, 6'sd10, 16'hABCD);
    clockwise = 1'b1; enable = 1'b1;
    step();
    check("bad idx t_out", t_out, mk(3'd7, 2'd2, -5'sd1, 6'sd10, 16'hABCD));
    check("bad idx done", 32'(done), 32'd1);
    check("bad idx success", 32'(success), 32'd0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst t_out", t_out, 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst success", 32'(success), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/rotate_tetromino.md
Name: rotate_tetromino

Overview:
- Single-cycle registered rotation unit for the active falling piece in the Tetris game core.
- On an `enable` request it rotates a `tetromino_ctrl` record clockwise or counter-clockwise:
  - advances the rotation index mod 4;
  - reloads the 4x4 occupancy mask from an internal SRS shape ROM.
- Returns `t_out` with a `done`/`success` pulse.
- Collision checking against the board is out of scope; the caller validates `t_out` downstream.

Parameters:
- None. All widths and constants come from the shared global package.

Ports:
- `clk` — input, 1 — system clock, rising-edge active.
- `rst_n` — input, 1 — asynchronous active-low reset.
- `enable` — input, 1 — rotation request, sampled at posedge `clk`.
- `clockwise` — input, 1 — 1 = clockwise (rotation+1), 0 = counter-clockwise (rotation-1).
- `t_in` — input, `tetromino_ctrl` — current piece: `idx.data[2:0]`, `rotation[1:0]`, `coordinate.x`/`coordinate.y` (signed), `tetromino.data` (4 rows x 4 bits).
- `t_out` — output, `tetromino_ctrl` — rotated piece (registered).
- `success` — output, 1 — rotation produced a valid piece (registered).
- `done` — output, 1 — one-cycle completion pulse (registered).

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `t_out` all fields zero;
  - `done`=0, `success`=0.
- Latency: exactly 1 cycle. Outputs update at the posedge where `enable`=1 and are valid immediately after that edge.
- Request with valid piece (`enable`=1 and `t_in.idx.data` in 0..6):
  - `t_out.rotation` = (`t_in.rotation` + 1) mod 4 if `clockwise`, else (`t_in.rotation` + 3) mod 4. This is 2-bit wrap arithmetic: 3→0 CW, 0→3 CCW, 1→0 CCW.
  - `t_out.idx` = `t_in.idx`; `t_out.coordinate` = `t_in.coordinate` (no kick offsets).
  - `t_out.tetromino.data` = SHAPE_ROM[idx][new rotation]. The incoming `t_in.tetromino.data` is ignored.
  - `done`=1, `success`=1.
- Request with invalid index (`enable`=1 and `idx`=7):
  - `t_out` = `t_in` unchanged;
  - `done`=1, `success`=0.
- Idle (`enable`=0):
  - `done`=0, `success`=0;
  - `t_out` holds its last value.
- Back-to-back requests:
  - `enable` held high for N cycles yields N independent rotations, each computed from the current `t_in`, with `done` high every cycle.
  - The module does not feed `t_out` back on its own.
- O piece: rotation index still advances; the shape mask is identical in all 4 states.
- Shape ROM: 7 pieces x 4 rotations x 16 bits, combinational, following standard SRS orientations inside a 4x4 box, row 0 = top. The I piece occupies row 1 in rotation 0.
- Piece indices: I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
- Reset asserted mid-request: outputs clear immediately; no pending state exists.

Decomposition:
- Shared global package holds:
  - `tetromino_ctrl` struct and its sub-structs (idx, coordinate, tetromino mask);
  - `TETROMINO_*_IDX` constants;
  - coordinate widths: x signed 5-bit, y signed 6-bit.
- One natural sub-module, `tetromino_shape_rom`: combinational lookup (idx, rotation) → 4x4 mask. It is reusable by spawn and rendering logic.

Test Plan:
- T piece, rot=0, `clockwise`=1, `enable` one cycle → after the edge `done`=1, `success`=1, `t_out.rotation`=1, mask = T rotation-1 shape, coordinate (3,0) preserved.
- T piece, rot=3, CW → `t_out.rotation`=0, `done`=1, `success`=1.
- T piece, rot=0, CCW → `t_out.rotation`=3; then rot=1, CCW → `t_out.rotation`=0.
- Hold behaviour: `enable` dropped → next cycle `done`=0, `success`=0, `t_out` unchanged.
- I piece, four CW rotations feeding `t_out` back to `t_in` → rotations 1, 2, 3, 0. Final mask equals the rotation-0 mask (row 1 = 4'b1111). O piece mask is constant across all four.
- `idx`=7 with `enable` → `done`=1, `success`=0, `t_out`==`t_in`. Assert `rst_n` low between edges → all outputs 0 without waiting for a clock edge.
